equals_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing the 2-bit equals pass-through channel among NUM_REQ requesters.

---
 rtl/equals_rr_arbiter_pkg.sv | 19 +
 rtl/equals_rr_arbiter_rr_pick.sv | 43 ++++
 rtl/equals_rr_arbiter.sv | 85 ++++++++
 tb/tb_equals_rr_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/equals_rr_arbiter_pkg.sv
// Shared types and helpers for the equals channel arbiter.
// Imported by the picker and the arbiter top.
package equals_arb_pkg;

  typedef enum logic {
    IDLE,
    FULL
  } arb_state_t;

  localparam int EQ_DATA_W = 2;

  function automatic int unsigned next_idx(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/equals_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first request after 'last'.
// Purely combinational.
import equals_arb_pkg::*;

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  // Walk last+1, last+2, ... and keep the first hit.
  always_comb begin
    int unsigned c;
    w_idx = '0;
    w_any = 1'b0;
    c     = 32'(last);
    for (int k = 0; k < NUM_REQ; k++) begin
      c = next_idx(c, NUM_REQ);
      if (!w_any && req[IDX_W'(c)]) begin
        w_idx = IDX_W'(c);
        w_any = 1'b1;
      end
    end
  end

  // One-hot view of the chosen index.
  always_comb begin
    gnt_onehot = '0;
    if (w_any) gnt_onehot[w_idx] = 1'b1;
  end

  assign gnt_idx = w_idx;
  assign any     = w_any;

endmodule

// File: rtl/equals_rr_arbiter.sv
// Round-robin arbiter feeding equals input 'a'.
// Single-entry output stage with backpressure.
import equals_arb_pkg::*;

module equals_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = EQ_DATA_W,
  parameter int CNT_W   = 16,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          xfer_cnt
);

  arb_state_t       r_state;
  logic [DATA_W-1:0] r_data;
  logic [SRC_W-1:0] r_src;
  logic [SRC_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;

  logic               w_can_load;
  logic               w_any;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_onehot;
  logic [SRC_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_pick (
    .req        (req_valid),
    .last       (r_last),
    .gnt_onehot (w_onehot),
    .gnt_idx    (w_idx),
    .any        (w_any)
  );

  assign w_can_load = (r_state == IDLE) | out_ready;
  assign w_accept   = w_can_load & w_any & rst_n;
  assign w_data     = req_data[w_idx*DATA_W +: DATA_W];

  // Grant is held off during reset so nothing is accepted then.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready = w_onehot;
  end

  // Output stage, pointer, counter and FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_src   <= '0;
      r_last  <= SRC_W'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_data <= w_data;
        r_src  <= w_idx;
        r_last <= w_idx;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      unique case (r_state)
        IDLE: if (w_accept) r_state <= FULL;
        FULL: if (out_ready && !w_accept) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_equals_rr_arbiter.sv
// Directed bench for equals_rr_arbiter.
// Counter narrowed to 4 bits to reach wrap.
module tb_equals_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic [CW-1:0]   xfer_cnt;

  int n_chk = 0;
  int n_err = 0;

  equals_rr_arbiter #(
    .NUM_REQ (NREQ),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_cnt", 32'(xfer_cnt), 0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_cnt", 32'(xfer_cnt), 0);
    chk("reset_data", 32'(out_data), 0);
    chk("reset_src", 32'(out_src), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 32'(out_valid), 0);

    // Single request from requester 2
    req_valid = 4'b0100;
    req_data  = 8'b00_11_00_00;
    out_ready = 1'b1;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 3);
    chk("single_src", 32'(out_src), 2);
    chk("single_cnt", 32'(xfer_cnt), 1);
    tick();
    chk("drain_idle", 32'(out_valid), 0);

    // All four valid, full throughput
    do_reset();
    req_valid = 4'b1111;
    req_data  = 8'b11_10_01_00;
    out_ready = 1'b1;
    #1;
    chk("all_first_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("all_src", 32'(out_src), 32'(k % 4));
      chk("all_data", 32'(out_data), 32'(k % 4));
      chk("all_valid", 32'(out_valid), 1);
    end
    req_valid = '0;
    #1;
    chk("all_cnt", 32'(xfer_cnt), 8);
    tick();
    chk("all_drain", 32'(out_valid), 0);

    // Backpressure
    req_valid = 4'b0010;
    req_data  = 8'b00_00_01_00;
    tick();
    chk("bp_load_src", 32'(out_src), 1);
    req_valid = 4'b1000;
    req_data  = 8'b10_00_00_00;
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(req_ready), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_data", 32'(out_data), 1);
      chk("bp_src", 32'(out_src), 1);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ready", 32'(req_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h8);
    tick();
    chk("bp_new_src", 32'(out_src), 3);
    chk("bp_new_data", 32'(out_data), 2);
    chk("bp_cnt", 32'(xfer_cnt), 10);

    // Single requester wins regardless of pointer
    req_valid = 4'b0100;
    req_data  = 8'b00_01_00_00;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("solo_ready", 32'(req_ready), 32'h4);
      tick();
      chk("solo_src", 32'(out_src), 2);
    end
    chk("solo_cnt", 32'(xfer_cnt), 13);

    // Counter wrap after 17 transfers
    req_valid = '0;
    do_reset();
    req_valid = 4'b1111;
    req_data  = 8'b11_10_01_00;
    repeat (17) tick();
    chk("wrap_cnt", 32'(xfer_cnt), 1);
    chk("wrap_src", 32'(out_src), 0);

    // Reset while FULL
    chk("mid_full", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_ready", 32'(req_ready), 0);
    chk("mid_cnt", 32'(xfer_cnt), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_first_ready", 32'(req_ready), 32'h1);
    tick();
    chk("mid_first_src", 32'(out_src), 0);
    chk("mid_first_cnt", 32'(xfer_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
